// File: rtl/axis_differentiator_mc.sv
// axis_differentiator_mc: per-channel y[n]=x[n]-x[n-DELAY] on an interleaved AXI-Stream (S_AXIS in, M_AXIS out with tuser=channel, tlast passthrough, sticky sync_err on misplaced tlast)
module axis_differentiator_mc #(
  parameter int IN_WIDTH = 32,
  parameter int OUT_WIDTH = 32,
  parameter int CHANNELS = 1,
  parameter int DELAY = 1,
  parameter bit SATURATE = 1,
  parameter int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 aclk,
  input  logic                 areset,
  input  logic [IN_WIDTH-1:0]  S_AXIS_tdata,
  input  logic                 S_AXIS_tvalid,
  output logic                 S_AXIS_tready,
  input  logic                 S_AXIS_tlast,
  output logic [OUT_WIDTH-1:0] M_AXIS_tdata,
  output logic                 M_AXIS_tvalid,
  input  logic                 M_AXIS_tready,
  output logic                 M_AXIS_tlast,
  output logic [CH_W-1:0]      M_AXIS_tuser,
  output logic                 sync_err
);
  localparam int PW = (DELAY > 1) ? $clog2(DELAY) : 1;
  localparam logic [CH_W-1:0] CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [PW-1:0] P_LAST = PW'(DELAY - 1);
  logic [IN_WIDTH-1:0] hist [2**CH_W][2**PW];
  logic [PW-1:0] ptr [2**CH_W];
  logic [CH_W-1:0] cnt;
  logic [IN_WIDTH-1:0] old;
  logic signed [IN_WIDTH:0] diff;
  logic [OUT_WIDTH-1:0] y;
  logic acc;
  assign S_AXIS_tready = !areset && (!M_AXIS_tvalid || M_AXIS_tready);
  assign acc = S_AXIS_tvalid && S_AXIS_tready;
  assign old = hist[cnt][ptr[cnt]];
  assign diff = $signed({S_AXIS_tdata[IN_WIDTH-1], S_AXIS_tdata}) - $signed({old[IN_WIDTH-1], old});
  generate
    if (SATURATE && OUT_WIDTH <= IN_WIDTH) begin : g_sat
      logic [IN_WIDTH-OUT_WIDTH+1:0] top;
      assign top = diff[IN_WIDTH:OUT_WIDTH-1];
      assign y = (&top || ~|top) ? diff[OUT_WIDTH-1:0] : {diff[IN_WIDTH], {(OUT_WIDTH-1){~diff[IN_WIDTH]}}};
    end else begin : g_cast
      assign y = OUT_WIDTH'(diff);
    end
  endgenerate
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt <= '0;
      sync_err <= 1'b0;
      M_AXIS_tvalid <= 1'b0;
      M_AXIS_tdata <= '0;
      M_AXIS_tlast <= 1'b0;
      M_AXIS_tuser <= '0;
      for (int i = 0; i < 2**CH_W; i++) begin
        ptr[i] <= '0;
        for (int j = 0; j < 2**PW; j++) hist[i][j] <= '0;
      end
    end else if (acc) begin
      hist[cnt][ptr[cnt]] <= S_AXIS_tdata;
      ptr[cnt] <= (ptr[cnt] == P_LAST) ? '0 : ptr[cnt] + 1'b1;
      cnt <= (S_AXIS_tlast || cnt == CH_LAST) ? '0 : cnt + 1'b1;
      sync_err <= sync_err | (S_AXIS_tlast && cnt != CH_LAST);
      M_AXIS_tdata <= y;
      M_AXIS_tlast <= S_AXIS_tlast;
      M_AXIS_tuser <= cnt;
      M_AXIS_tvalid <= 1'b1;
    end else if (M_AXIS_tready) begin
      M_AXIS_tvalid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_axis_differentiator_mc.sv
// tb_axis_differentiator_mc: several differentiator configurations driven in lockstep against a queue-based reference model
module tb_axis_differentiator_mc;
  localparam int NG = 6;
  localparam int IWS [NG] = '{32, 32, 16, 16, 12, 12};
  localparam int OWS [NG] = '{32, 32, 16, 16, 14, 10};
  localparam int CS  [NG] = '{1, 2, 1, 1, 4, 3};
  localparam int DS  [NG] = '{1, 2, 1, 1, 3, 5};
  localparam int SS  [NG] = '{1, 1, 1, 0, 1, 0};
  typedef struct { longint d; bit l; int u; } beat_t;
  logic aclk, areset, svalid, slast, mready;
  logic [31:0] sdata;
  logic signed [63:0] od [NG];
  logic [31:0] ou [NG];
  logic mv [NG];
  logic ol [NG];
  logic sr [NG];
  logic se [NG];
  beat_t expq [NG][$];
  beat_t logq [NG][$];
  longint hq [NG][16][$];
  int ch [NG];
  bit serr [NG];
  int checks = 0;
  int errors = 0;
  generate
    for (genvar g = 0; g < NG; g++) begin : g_dut
      localparam int CHW = (CS[g] > 1) ? $clog2(CS[g]) : 1;
      logic [OWS[g]-1:0] md;
      logic [CHW-1:0] mu;
      axis_differentiator_mc #(
        .IN_WIDTH(IWS[g]), .OUT_WIDTH(OWS[g]), .CHANNELS(CS[g]), .DELAY(DS[g]), .SATURATE(SS[g] != 0)
      ) u_dut (
        .aclk(aclk), .areset(areset),
        .S_AXIS_tdata(sdata[IWS[g]-1:0]), .S_AXIS_tvalid(svalid), .S_AXIS_tready(sr[g]), .S_AXIS_tlast(slast),
        .M_AXIS_tdata(md), .M_AXIS_tvalid(mv[g]), .M_AXIS_tready(mready), .M_AXIS_tlast(ol[g]),
        .M_AXIS_tuser(mu), .sync_err(se[g])
      );
      assign od[g] = 64'($signed(md));
      assign ou[g] = 32'(mu);
    end
  endgenerate
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;
  function automatic longint sx(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction
  function automatic longint clamp(longint v, int w);
    longint mx = (longint'(1) <<< (w - 1)) - 1;
    return v > mx ? mx : (v < -mx - 1 ? -mx - 1 : v);
  endfunction
  always @(posedge areset) begin
    for (int k = 0; k < NG; k++) begin
      expq[k].delete();
      logq[k].delete();
      ch[k] = 0;
      serr[k] = 1'b0;
      for (int c = 0; c < 16; c++) hq[k][c].delete();
    end
  end
  always @(posedge aclk) begin
    if (!areset) begin
      for (int k = 0; k < NG; k++) begin
        bit rdy;
        rdy = expq[k].size() == 0 || mready;
        if (expq[k].size() > 0 && mready) logq[k].push_back(expq[k].pop_front());
        if (svalid && rdy) begin
          longint x, h, v, y;
          int c, n;
          c = ch[k];
          x = sx(longint'(sdata), IWS[k]);
          n = hq[k][c].size();
          h = (n >= DS[k]) ? hq[k][c][n - DS[k]] : 0;
          v = x - h;
          y = (SS[k] != 0) ? clamp(v, OWS[k]) : sx(v, OWS[k]);
          expq[k].push_back(beat_t'{d: y, l: slast, u: c});
          hq[k][c].push_back(x);
          if (hq[k][c].size() > DS[k]) void'(hq[k][c].pop_front());
          if (slast && c != CS[k] - 1) serr[k] = 1'b1;
          ch[k] = (slast || c == CS[k] - 1) ? 0 : c + 1;
        end
      end
    end
  end
  always @(negedge aclk) begin
    for (int k = 0; k < NG; k++) begin
      checks++;
      if (mv[k] !== (expq[k].size() > 0)) begin
        errors++;
        $display("FAIL tvalid g%0d: got %0b want %0b", k, mv[k], expq[k].size() > 0);
      end
      checks++;
      if (se[k] !== serr[k]) begin
        errors++;
        $display("FAIL sync_err g%0d: got %0b want %0b", k, se[k], serr[k]);
      end
      if (!areset) begin
        checks++;
        if (sr[k] !== (expq[k].size() == 0 || mready)) begin
          errors++;
          $display("FAIL s_tready g%0d: got %0b want %0b", k, sr[k], expq[k].size() == 0 || mready);
        end
      end
      if (expq[k].size() > 0) begin
        checks++;
        if (od[k] !== expq[k][0].d || ol[k] !== expq[k][0].l || ou[k] !== 32'(expq[k][0].u)) begin
          errors++;
          $display("FAIL beat g%0d: got d=%0d l=%0b u=%0d want d=%0d l=%0b u=%0d",
                   k, od[k], ol[k], ou[k], expq[k][0].d, expq[k][0].l, expq[k][0].u);
        end
      end
    end
  end
  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask
  task automatic send(input logic [31:0] d, input logic l);
    logic r;
    bit done;
    done = 1'b0;
    svalid = 1'b1;
    sdata = d;
    slast = l;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge aclk);
      r = sr[0];
      @(posedge aclk);
      done = r;
    end
    #1;
    svalid = 1'b0;
    slast = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL send_timeout: got no accept want accept");
    end
  endtask
  task automatic idle(input int n);
    svalid = 1'b0;
    repeat (n) @(posedge aclk);
    #1;
  endtask
  task automatic do_reset();
    @(negedge aclk);
    #2 areset = 1'b1;
    svalid = 1'b0;
    slast = 1'b0;
    mready = 1'b1;
    @(negedge aclk);
    #2 areset = 1'b0;
    @(posedge aclk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] ext [6];
    logic r;
    ext = '{32'h7fffffff, 32'h80000000, 32'h00000800, 32'h000007ff, 32'hffff8000, 32'h00007fff};
    areset = 1'b1;
    svalid = 1'b0;
    slast = 1'b0;
    sdata = '0;
    mready = 1'b1;
    #3;
    chk("reset_tvalid", mv[0], 0);
    chk("reset_tdata", od[1], 0);
    chk("reset_tuser", ou[4], 0);
    chk("reset_sync_err", se[4], 0);
    #4 areset = 1'b0;
    @(posedge aclk);
    #1;
    foreach (ext[i]) ;
    send(32'd0, 0); send(32'd5, 0); send(32'd12, 0); send(32'd12, 0); send(-32'sd3, 0);
    idle(3);
    chk("ramp_count", logq[0].size(), 5);
    chk("ramp0", logq[0][0].d, 0);
    chk("ramp1", logq[0][1].d, 5);
    chk("ramp2", logq[0][2].d, 7);
    chk("ramp3", logq[0][3].d, 0);
    chk("ramp4", logq[0][4].d, -15);
    chk("ramp_tuser", logq[0][4].u, 0);
    do_reset();
    send(32'd10, 0); send(32'd100, 0); send(32'd20, 0); send(32'd90, 0);
    send(32'd30, 0); send(32'd80, 0); send(32'd40, 0); send(32'd70, 0);
    idle(3);
    chk("il_count", logq[1].size(), 8);
    chk("il_a2", logq[1][4].d, 20);
    chk("il_a3", logq[1][6].d, 20);
    chk("il_b1", logq[1][3].d, 90);
    chk("il_b2", logq[1][5].d, -20);
    chk("il_b3", logq[1][7].d, -20);
    chk("il_tuser0", logq[1][6].u, 0);
    chk("il_tuser1", logq[1][7].u, 1);
    do_reset();
    send(32'h00007fff, 0); send(32'hffff8000, 0);
    idle(3);
    chk("sat_first", logq[2][0].d, 32767);
    chk("sat_clamp", logq[2][1].d, -32768);
    chk("wrap", logq[3][1].d, 1);
    do_reset();
    svalid = 1'b1;
    sdata = 32'd7;
    @(posedge aclk);
    #1;
    mready = 1'b0;
    sdata = 32'd9;
    repeat (3) begin
      @(negedge aclk);
      chk("bp_ready", sr[0], 0);
      chk("bp_hold", od[0], 7);
      @(posedge aclk);
      #1;
    end
    mready = 1'b1;
    send(32'd9, 0);
    idle(3);
    chk("bp_count", logq[0].size(), 2);
    chk("bp_second", logq[0][1].d, 2);
    do_reset();
    send(32'd1, 0); send(32'd2, 0); send(32'd3, 1); send(32'd4, 0);
    idle(3);
    chk("sync_set", se[4], 1);
    chk("sync_tlast", logq[4][2].l, 1);
    chk("sync_next_tuser", logq[4][3].u, 0);
    idle(2);
    chk("sync_sticky", se[4], 1);
    mready = 1'b0;
    svalid = 1'b1;
    sdata = 32'd55;
    @(posedge aclk);
    #2 areset = 1'b1;
    #1;
    chk("arst_tvalid", mv[1], 0);
    chk("arst_sync_err", se[4], 0);
    svalid = 1'b0;
    mready = 1'b1;
    @(negedge aclk);
    #2 areset = 1'b0;
    send(32'd1234, 0);
    idle(3);
    chk("arst_first", logq[0][0].d, 1234);
    chk("arst_first_d2", logq[1][0].d, 1234);
    for (int i = 0; i < 3000; i++) begin
      @(negedge aclk);
      r = sr[0];
      @(posedge aclk);
      #1;
      if (i == 1500) begin
        #2 areset = 1'b1;
        svalid = 1'b0;
        #3 areset = 1'b0;
      end
      if (!svalid || r) begin
        svalid = $urandom_range(0, 3) != 0;
        sdata = ($urandom_range(0, 7) == 0) ? ext[$urandom_range(0, 5)] : $urandom();
        slast = $urandom_range(0, 4) == 0;
      end
      mready = $urandom_range(0, 3) != 0;
    end
    mready = 1'b1;
    idle(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_differentiator_mc.md
Name: axis_differentiator_mc

Overview:
Parametrised successor of the single-channel AXI-Stream differentiator. Computes y[n] = x[n] - x[n-DELAY] independently for CHANNELS time-interleaved channels sharing one stream. Supports a configurable lag, output width, wrap/saturate mode, full backpressure and frame-sync checking via tlast. Sits between the ADC/phase-demodulator stream and downstream filtering/FFT cores.

Parameters:
IN_WIDTH, 32, signed input sample width
OUT_WIDTH, 32, signed output sample width
CHANNELS, 1, interleaved channels per frame (1..16)
DELAY, 1, lag in samples per channel (1..64)
SATURATE, 1, 1 = clamp to OUT_WIDTH range; 0 = two's-complement wrap
CH_W, max(1,clog2(CHANNELS)), channel index width (derived)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
S_AXIS_tdata  in  IN_WIDTH  signed input sample
S_AXIS_tvalid  in  1  input valid
S_AXIS_tready  out  1  input ready
S_AXIS_tlast  in  1  marks last channel of a frame
M_AXIS_tdata  out  OUT_WIDTH  signed difference
M_AXIS_tvalid  out  1  output valid
M_AXIS_tready  in  1  downstream ready
M_AXIS_tlast  out  1  tlast passed through with its sample
M_AXIS_tuser  out  CH_W  channel index of output sample
sync_err  out  1  sticky frame-misalignment flag

Behaviour:
- One clock (aclk); reset is asynchronous and active-high (areset). All state clears immediately on assertion.
- Reset values: M_AXIS_tvalid=0, M_AXIS_tdata=0, M_AXIS_tlast=0, M_AXIS_tuser=0, sync_err=0, channel counter=0, all history entries=0, ring pointer=0. S_AXIS_tready=1 from first clock after release.
- History: CHANNELS x DELAY register ring. Per channel, a circular pointer (0..DELAY-1) advances on each accepted sample of that channel and wraps DELAY-1 -> 0. Entry read = x[n-DELAY], then overwritten with x[n] in the same cycle.
- Priming: history starts zero, so the first DELAY outputs per channel equal the input sample (minus 0). No suppression.
- Arithmetic: diff = sext(x) - sext(hist), computed in IN_WIDTH+1 bits, exact.
  - OUT_WIDTH >= IN_WIDTH+1: sign-extend.
  - Otherwise, SATURATE=1 clamps to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]; SATURATE=0 keeps the low OUT_WIDTH bits.
- Handshake: accept = S_AXIS_tvalid && S_AXIS_tready. S_AXIS_tready = !M_AXIS_tvalid || M_AXIS_tready (single output register, no combinational tdata path).
  - Latency is 1 cycle from accept to M_AXIS_tvalid.
  - Full throughput of 1 sample/cycle while M_AXIS_tready=1.
  - M_AXIS_tvalid drops after a consumed beat with no new accept.
  - M_AXIS_tdata, tlast and tuser are held stable while tvalid=1 and tready=0.
  - Accept and consume in the same cycle: the output register reloads and tvalid stays 1.
- Channel counter: M_AXIS_tuser = counter value at accept. Counter increments on accept and wraps CHANNELS-1 -> 0.
- Frame sync:
  - S_AXIS_tlast=1 on accept with counter != CHANNELS-1 sets sync_err (sticky until reset) and forces the counter to 0 for the next sample.
  - Counter == CHANNELS-1 without tlast is not an error. Tlast is optional.
- Reset mid-stream: an in-flight output is discarded and history cleared. Upstream must not rely on the beat held at reset.
- Input values are ignored when tvalid=0. History and counters change only on accept.

Test Plan:
- CHANNELS=1, DELAY=1, IN=OUT=32, ramp 0,5,12,12,-3 with tready=1 -> outputs 0,5,7,0,-15, tvalid 1 cycle after each accept, tuser=0.
- CHANNELS=2, DELAY=2, interleaved A:10,20,30,40 / B:100,90,80,70 -> A outputs 10,20,20,20; B outputs 100,90,-20,-20; tuser alternates 0,1.
- IN=16, OUT=16, SATURATE=1: 32767 then -32768 (DELAY=1) -> second output -32768 (clamped from -65535). Same with SATURATE=0 -> second output 1 (wrapped).
- Backpressure: tready low for 3 cycles mid-stream with tvalid held high -> S_AXIS_tready=0 after one buffered beat, M_AXIS_tdata stable, no sample lost or duplicated, sequence matches golden model.
- CHANNELS=4, tlast on the 3rd sample -> sync_err=1 and stays 1; next sample gets tuser=0; M_AXIS_tlast tracks the input tlast.
- Assert areset asynchronously mid-stream with tvalid=1 -> tvalid=0 and sync_err=0 immediately; after release the first output equals the raw input (history cleared).
